// File: rtl/ram_scroll_viewer_pkg.sv
// Shared types and helpers for the RAM scroll viewer: mode encodings,
// seven-segment constants and the digit-count helper.
package ram_scroll_pkg;

  typedef enum logic [1:0] {
    MODE_MANUAL = 2'b00,
    MODE_UP     = 2'b01,
    MODE_DOWN   = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  // Segments are {g,f,e,d,c,b,a}, active-low
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;

  function automatic int ceil_div4(input int width);
    return (width + 3) / 4;
  endfunction

endpackage

// File: rtl/ram_scroll_viewer_if.sv
// Switch/display bundle of the RAM scroll viewer; the viewer is the slave,
// the board (or bench) is the master.
interface ram_scroll_viewer_if import ram_scroll_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) ();
  localparam int DIGITS  = ceil_div4(DATA_W);
  localparam int ADIGITS = ceil_div4(ADDR_W);

  logic [DATA_W-1:0]    DATA;
  logic [ADDR_W-1:0]    ADDRESS;
  logic                 WE;
  logic [1:0]           MODE;
  logic [DATA_W-1:0]    Q;
  logic [ADDR_W-1:0]    CUR_ADDR;
  logic                 TICK;
  logic [7*DIGITS-1:0]  DISP;
  logic [7*ADIGITS-1:0] ADDR_DISP;

  modport master (
    output DATA, ADDRESS, WE, MODE,
    input  Q, CUR_ADDR, TICK, DISP, ADDR_DISP
  );

  modport slave (
    input  DATA, ADDRESS, WE, MODE,
    output Q, CUR_ADDR, TICK, DISP, ADDR_DISP
  );
endinterface

// File: rtl/ram_scroll_viewer_hex7seg.sv
// One hex digit decoder: 4-bit nibble to active-low segments {g..a}.
module hex7seg import ram_scroll_pkg::*; (
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);
  always_comb begin
    o_seg = SEG_BLANK;
    unique case (i_nib)
      4'h0: o_seg = SEG_ZERO;
      4'h1: o_seg = 7'b1111001;
      4'h2: o_seg = 7'b0100100;
      4'h3: o_seg = 7'b0110000;
      4'h4: o_seg = 7'b0011001;
      4'h5: o_seg = 7'b0010010;
      4'h6: o_seg = 7'b0000010;
      4'h7: o_seg = 7'b1111000;
      4'h8: o_seg = 7'b0000000;
      4'h9: o_seg = 7'b0010000;
      4'hA: o_seg = 7'b0001000;
      4'hB: o_seg = 7'b0000011;
      4'hC: o_seg = 7'b1000110;
      4'hD: o_seg = 7'b0100001;
      4'hE: o_seg = 7'b0000110;
      4'hF: o_seg = 7'b0001110;
      default: o_seg = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/ram_scroll_viewer.sv
// RAM viewer: manual write/read from switches, or auto-scroll up/down/hold.
// Define RAM_SCROLL_ADDR_DISP_EN to drive ADDR_DISP with the hex of CUR_ADDR.
module ram_scroll_viewer import ram_scroll_pkg::*; #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 5,
  parameter int TICK_DIV = 50_000_000
) (
  input logic               CLK,
  input logic               RESET_N,
  ram_scroll_viewer_if.slave bus
);
  // state        | meaning
  // MODE_MANUAL  | last cycle was manual: switches drive address/writes
  // MODE_UP      | last cycle was scrolling up
  // MODE_DOWN    | last cycle was scrolling down
  // MODE_HOLD    | last cycle was frozen
  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int DIGITS = ceil_div4(DATA_W);
  localparam int TW     = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TCNT_LAST = TW'(TICK_DIV - 1);

  mode_e             w_mode, r_state, w_state_nxt;
  logic              w_mode_chg, w_scroll, w_tick, w_we;
  logic [ADDR_W-1:0] r_scnt, w_cur_addr;
  logic [TW-1:0]     r_tcnt;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_q;
  logic [4*DIGITS-1:0] w_q_ext;
  logic [7*DIGITS-1:0] w_disp;

  assign w_mode = mode_e'(bus.MODE);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) r_state <= MODE_MANUAL;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = w_mode;
  end

  // A mode that differs from last cycle's suppresses the step, so the new mode wins.
  always_comb begin
    w_mode_chg = (w_mode != r_state);
    w_scroll   = (w_mode == MODE_UP) || (w_mode == MODE_DOWN);
    w_tick     = w_scroll && !w_mode_chg && (r_tcnt == TCNT_LAST);
    w_we       = bus.WE && (w_mode == MODE_MANUAL);
    w_cur_addr = (w_mode == MODE_MANUAL) ? bus.ADDRESS : r_scnt;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)                                   r_tcnt <= '0;
    else if (w_mode == MODE_MANUAL || w_mode_chg)   r_tcnt <= '0;
    else if (r_tcnt == TCNT_LAST)                   r_tcnt <= '0;
    else                                            r_tcnt <= r_tcnt + 1'b1;
  end

  // Tracking ADDRESS in manual mode makes scrolling start from the last manual address.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_scnt <= '0;
    end else begin
      unique case (w_mode)
        MODE_MANUAL: r_scnt <= bus.ADDRESS;
        MODE_UP:     if (w_tick) r_scnt <= r_scnt + 1'b1;
        MODE_DOWN:   if (w_tick) r_scnt <= r_scnt - 1'b1;
        MODE_HOLD:   r_scnt <= r_scnt;
        default:     r_scnt <= r_scnt;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (w_we) r_mem[bus.ADDRESS] <= bus.DATA;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) r_q <= '0;
    else          r_q <= r_mem[w_cur_addr];
  end

  always_comb begin
    w_q_ext = '0;
    w_q_ext[DATA_W-1:0] = r_q;
  end

  for (genvar k = 0; k < DIGITS; k++) begin : g_disp
    hex7seg u_hex (
      .i_nib (w_q_ext[4*k +: 4]),
      .o_seg (w_disp[7*k +: 7])
    );
  end

  assign bus.Q        = r_q;
  assign bus.CUR_ADDR = w_cur_addr;
  assign bus.TICK     = w_tick;
  assign bus.DISP     = w_disp;

`ifdef RAM_SCROLL_ADDR_DISP_EN
  localparam int ADIGITS = ceil_div4(ADDR_W);
  logic [4*ADIGITS-1:0] w_addr_ext;
  logic [7*ADIGITS-1:0] w_adisp;

  always_comb begin
    w_addr_ext = '0;
    w_addr_ext[ADDR_W-1:0] = w_cur_addr;
  end

  for (genvar k = 0; k < ADIGITS; k++) begin : g_adisp
    hex7seg u_hex (
      .i_nib (w_addr_ext[4*k +: 4]),
      .o_seg (w_adisp[7*k +: 7])
    );
  end

  assign bus.ADDR_DISP = w_adisp;
`else
  assign bus.ADDR_DISP = '1;
`endif

endmodule

// File: doc/ram_scroll_viewer.md
# ram_scroll_viewer

Parametrised RAM viewer for the DE2-115 board. It holds an inferred single-port synchronous RAM that is written from the switches in manual mode. In scroll mode it steps automatically through every address, up or down, at a divided tick rate. Each read word is shown on active-low seven-segment digits. It supersedes the fixed 8×32 scroll lab block and adds direction control, hold, wrap rules and parametric sizing.

## Interface
- DATA_W, 8, RAM word width; DIGITS = ceil(DATA_W/4) display digits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W
- TICK_DIV, 50_000_000, clock cycles per scroll step; must be ≥ 2
- CLK  in  1  system clock, all logic on posedge
- RESET_N  in  1  asynchronous, active-low reset
- DATA  in  DATA_W  write data
- ADDRESS  in  ADDR_W  manual read/write address
- WE  in  1  write enable; honoured only in MODE_MANUAL
- MODE  in  2  00 manual, 01 scroll up, 10 scroll down, 11 hold
- Q  out  DATA_W  registered RAM read data
- CUR_ADDR  out  ADDR_W  address currently driving the RAM
- TICK  out  1  one-cycle pulse per scroll step
- DISP  out  7*DIGITS  hex of Q; digit k = Q[4k+3:4k], segments {g..a}, active-low
- ADDR_DISP  out  7*ceil(ADDR_W/4)  hex of CUR_ADDR, same encoding

## Operation
- Reset values:
  - scroll counter SCNT = 0; tick counter = 0
  - Q = 0, so DISP shows all "0" digits (7'b1000000 each)
  - TICK = 0; CUR_ADDR = 0
  - RAM contents are not reset.
- Address select: in MODE_MANUAL, CUR_ADDR = ADDRESS; in every other mode, CUR_ADDR = SCNT.
- Write:
  - WE=1 in MODE_MANUAL writes DATA to RAM[ADDRESS] at the clock edge.
  - In any other mode, WE is ignored and the RAM is unchanged.
- Read: each edge, Q <= RAM[CUR_ADDR]. Read-during-write returns the old data, and the new data appears one cycle later.
- Tick counter:
  - Cleared in MODE_MANUAL and in the cycle after any MODE change.
  - Otherwise counts 0..TICK_DIV-1 and wraps.
  - TICK = 1 while count == TICK_DIV-1 and mode is 01 or 10.
- Scroll counter states:
  - MANUAL: SCNT <= ADDRESS every cycle, so scrolling starts from the last manual address.
  - UP: SCNT += 1 on TICK; DEPTH-1 wraps to 0.
  - DOWN: SCNT -= 1 on TICK; 0 wraps to DEPTH-1.
  - HOLD: SCNT frozen and TICK held 0. Entering UP or DOWN from HOLD resumes from the frozen SCNT.
- Arithmetic: SCNT arithmetic is modulo 2**ADDR_W. If DATA_W is not a multiple of 4, the top digit is zero-extended.

## Timing
- Read latency is 1 cycle: a change on CUR_ADDR is reflected on Q at the next edge. DISP is combinational from Q.
- TICK_DIV=N: the first step occurs N cycles after entering a scroll mode, and later steps every N cycles.
- A MODE change coinciding with TICK: the new mode wins and no step is taken.
- Asserting RESET_N low mid-scroll returns all state to reset values immediately. Release is synchronised by the board reset logic, outside this block.

## Configuration
- RAM_SCROLL_ADDR_DISP_EN defined: ADDR_DISP is driven with the hex of CUR_ADDR.
- Not defined: ADDR_DISP is tied to all-ones (blank digits) and no address decoders are built.
- DISP, Q and CUR_ADDR are unaffected either way.

## Structure
- Package ram_scroll_pkg holds:
  - mode encodings MODE_MANUAL, MODE_UP, MODE_DOWN, MODE_HOLD
  - seven-segment constants SEG_BLANK and SEG_ZERO
  - a ceil_div4 function for digit counts
- One sub-module, hex7seg (4-bit nibble to 7-bit active-low segments), instantiated per digit by a generate loop.
- RAM, tick divider and scroll counter stay inline.

## Test plan
- Bench parameters: DATA_W=8, ADDR_W=3, TICK_DIV=4.
- Reset: pulse RESET_N low for 1 cycle → Q=0x00, DISP=14'h2040 (two zeros), TICK=0, CUR_ADDR=0.
- Manual write/read:
  - Write 0xA5 to address 3, then 0x3C to 7.
  - Set ADDRESS=3 with WE=0 → Q=0xA5 one cycle later; DISP digits show "A5".
- Scroll up with wrap:
  - Fill RAM[i]=0x10+i, set ADDRESS=6, MODE=01.
  - → TICK every 4 cycles; CUR_ADDR sequence 6,7,0,1.
  - Q follows one cycle behind: 0x16,0x17,0x10,0x11.
- Scroll down with wrap, from ADDRESS=1: MODE=10 → CUR_ADDR 1,0,7,6.
- Hold and write-ignore:
  - Scrolling at 5, switch to MODE=11 and pulse WE=1 with DATA=0xFF.
  - → CUR_ADDR stays 5 and TICK stays 0 for 20 cycles.
  - RAM[5] is unchanged; read it back in manual mode.
- Reset mid-scroll: assert RESET_N low at CUR_ADDR=4 → Q and SCNT are 0 in the same cycle. Previously written RAM data is still readable after release.
